// File: rtl/pseudo_checker_pkg.sv
// Shared definitions for the pseudo PRBS generator and its receive-side checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pseudo_checker_pkg;

    // 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1 -> feedback taps s[15,13,12,10]
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SYNC0  = 2'd0,
        SYNC1  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Advance the LFSR by one byte (8 feedback steps); the new low byte is the emitted byte.
    function automatic logic [LFSR_W-1:0] lfsr_adv8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
        end
        return v;
    endfunction

endpackage

// File: rtl/pseudo_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible one cycle after the increment/clear is sampled.
// Backpressure: none; holds at all-ones once saturated.
module pseudo_checker_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up on i_inc, stick at the maximum, clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pseudo_checker.sv
// PRBS checker: self-syncs a local 16-bit LFSR copy from the byte stream, locks, counts byte errors.
// Latency: all outputs registered, updated on the edge that samples the byte (visible next cycle).
// Backpressure: none; one byte is consumed on every cycle with valid_i & enable_i.
module pseudo_checker
    import pseudo_checker_pkg::*;
#(
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] byte_count_o
);

    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    state_t              r_state, w_state_nxt;
    logic [LFSR_W-1:0]   r_s, w_s_nxt;
    logic [MATCH_W-1:0]  r_match, w_match_nxt, w_match_inc;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt, w_miss_inc;
    logic                r_locked, r_err;
    logic                w_take, w_err, w_byte_inc;
    logic [LFSR_W-1:0]   w_adv;
    logic                w_hit;

    assign w_take      = valid_i & enable_i;
    assign w_adv       = lfsr_adv8(r_s);
    assign w_hit       = (w_adv[7:0] == data_i);
    assign w_match_inc = r_match + 1'b1;
    assign w_miss_inc  = r_miss + 1'b1;

    // Next-state, LFSR update and per-byte error/count strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        w_err       = 1'b0;
        w_byte_inc  = 1'b0;
        if (w_take) begin
            case (r_state)
                SYNC0: begin
                    w_s_nxt     = {data_i, r_s[7:0]};
                    w_state_nxt = SYNC1;
                end
                SYNC1: begin
                    w_s_nxt = {r_s[15:8], data_i};
                    // all-zero is the LFSR lock-up state, never a valid seed
                    if ({r_s[15:8], data_i} == '0) begin
                        w_state_nxt = SYNC0;
                    end else begin
                        w_state_nxt = CHECK;
                        w_match_nxt = '0;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        w_s_nxt = w_adv;
                        if (w_match_inc == MATCH_W'(LOCK_THRESH)) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_state_nxt = SYNC0;
                    end
                end
                LOCKED: begin
                    // follow the prediction, not the data, so a corrupted byte errs only once
                    w_s_nxt    = w_adv;
                    w_byte_inc = 1'b1;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err = 1'b1;
                        if (w_miss_inc == MISS_W'(LOSS_THRESH)) begin
                            w_state_nxt = SYNC0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: w_state_nxt = SYNC0;
            endcase
        end
    end

    // State, LFSR copy, internal run counters and registered status outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= SYNC0;
            r_s      <= '0;
            r_match  <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s      <= w_s_nxt;
            r_match  <= w_match_nxt;
            r_miss   <= w_miss_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_err    <= w_err;
        end
    end

    pseudo_checker_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_inc   (w_err),
        .i_clr   (clear_i),
        .o_cnt   (err_count_o)
    );

    pseudo_checker_sat_counter #(.CNT_W(CNT_W)) u_byte_cnt (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_inc   (w_byte_inc),
        .i_clr   (clear_i),
        .o_cnt   (byte_count_o)
    );

    assign locked_o = r_locked;
    assign err_o    = r_err;

endmodule

// File: doc/pseudo_checker.md
# pseudo_checker

- Receive-side PRBS checker for the `pseudo` LFSR generator.
- Consumes the generator's 8-bit output byte stream together with its per-byte strobe.
- Self-synchronises a local copy of the 16-bit LFSR, declares lock, and counts byte errors.
- Sits in the user project next to `pseudo`, either looped back on-chip or fed from the io pads, for link and BIST checking.

## Interface
Parameters:
- LOCK_THRESH, 4: consecutive matching bytes needed to declare lock.
- LOSS_THRESH, 4: consecutive mismatching bytes, while locked, that drop lock.
- CNT_W, 16: width of the error and byte counters.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  checker enable; when 0, state is held and strobes are ignored.
- clear_i  in  1  synchronous clear of both counters; the FSM is unaffected.
- data_i  in  8  received byte.
- valid_i  in  1  byte strobe; one byte per cycle where valid_i=1.
- locked_o  out  1  high in LOCKED.
- err_o  out  1  one-cycle pulse per mismatching byte while locked.
- err_count_o  out  CNT_W  saturating mismatch count.
- byte_count_o  out  CNT_W  saturating count of bytes checked while locked.

## Operation
LFSR definition (must match `pseudo`):
- 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- Per bit: fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0], fb}.
- A byte is 8 successive fb bits; the first bit goes to data[7].
- Consequence: after 8 steps the byte equals the new s[7:0].

FSM states: SYNC0, SYNC1, CHECK, LOCKED. Every transition is taken only on a cycle with valid_i & enable_i.
- SYNC0: s[15:8] <= data_i; go to SYNC1.
- SYNC1:
  - s[7:0] <= data_i.
  - If {s[15:8], data_i}==0, go back to SYNC0; an all-zero state is illegal.
  - Otherwise go to CHECK with match counter = 0.
- CHECK: compute expected byte by advancing s 8 steps.
  - Match: s <= advanced state; match counter +1; go to LOCKED when it reaches LOCK_THRESH.
  - Mismatch: go to SYNC0. No error is counted.
- LOCKED: compute expected byte by advancing s 8 steps; s <= advanced (predicted) state regardless of result, so one corrupted byte counts once.
  - Match: clear the miss counter; byte_count +1.
  - Mismatch: err_o pulse; err_count +1; byte_count +1; miss counter +1. On reaching LOSS_THRESH, go to SYNC0 and deassert locked_o.
- Counters saturate at 2^CNT_W-1.
- clear_i zeroes both counters. If clear_i and an increment occur in the same cycle, the counter becomes 0; clear wins.
- enable_i=0: nothing advances, err_o=0, counters hold; clear_i still acts.

## Timing
- Reset (async assert, sync-safe deassert): state SYNC0, s=0, locked_o=0, err_o=0, both counters 0, internal match/miss counters 0.
- All outputs are registered.
- err_o, the counters, and locked_o update on the clock edge that samples the qualifying byte. They are visible one cycle after valid_i.
- Minimum lock latency: 2 + LOCK_THRESH valid bytes.
- valid_i may be high every cycle or sparse. Gaps do not affect state.
- Reset asserted mid-stream returns everything to reset values immediately. The stream must then re-acquire from SYNC0.

## Structure
- Shared package holds:
  - LFSR width (16) and tap mask.
  - FSM state enum {SYNC0, SYNC1, CHECK, LOCKED}.
  - Function lfsr_adv8(s) returning the state advanced 8 steps.
- `pseudo` uses the same package so the polynomial is defined once.
- Natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.

## Test plan
- Seed lock: LOCK_THRESH=1; bytes 0xAC, 0xE1, 0xE4 (0xACE1 advanced 8 steps gives s=0xE1E4) -> locked_o=1 one cycle after 0xE4; err_count=0; byte_count=0.
- Continuous stream: `pseudo` model from seed 0xACE1, 1000 bytes, defaults -> locked after byte 6; err_count=0; byte_count=994.
- Single bit flip: after lock, flip bit 3 of one byte -> exactly one err_o pulse; err_count=1; locked_o stays 1; following bytes match.
- Loss of lock: after lock, 4 bytes of 0x00 -> err_count=4; locked_o=0 after the 4th; then clean stream -> relock after 6 more bytes.
- All-zero seed: bytes 0x00, 0x00 -> remains in SYNC0/SYNC1 cycling; locked_o never 1.
- Clear/reset: clear_i coincident with a mismatch -> err_count=0; wb_rst_ni pulse mid-stream -> all outputs 0 on the next sample; relock after 6 bytes.
